// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_pkg
// Brief   : Shared types and lane helpers for the MIPS memory stage.
// Revision: 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam logic [3:0] c_be_byte    = 4'b0001;
  localparam logic [3:0] c_be_half_lo = 4'b0011;
  localparam logic [3:0] c_be_half_hi = 4'b1100;
  localparam logic [3:0] c_be_word    = 4'b1111;

  // Byte wins when both size bits are set.
  function automatic size_e decode_size(input logic is_byte, input logic is_half);
    size_e size;
    if (is_byte) begin
      size = SIZE_BYTE;
    end else if (is_half) begin
      size = SIZE_HALF;
    end else begin
      size = SIZE_WORD;
    end
    return size;
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
    logic bad;
    case (size)
      SIZE_HALF: bad = lane[0];
      SIZE_WORD: bad = |lane;
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_enables(input size_e size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = c_be_byte << lane;
      SIZE_HALF: be = lane[1] ? c_be_half_hi : c_be_half_lo;
      default:   be = c_be_word;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate_store(input size_e size, input logic [31:0] wdata);
    logic [31:0] rep;
    case (size)
      SIZE_BYTE: rep = {4{wdata[7:0]}};
      SIZE_HALF: rep = {2{wdata[15:0]}};
      default:   rep = wdata;
    endcase
    return rep;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_aligner.sv
`default_nettype none
// ============================================================================
// Module  : mem_load_aligner
// Brief   : Selects the addressed byte/half of a read word and extends it.
// Revision: 1.0 - initial release
// ============================================================================
module mem_load_aligner
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  size_e       i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_load_value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (i_lane)
      2'd0:    byte_sel = i_rdata[7:0];
      2'd1:    byte_sel = i_rdata[15:8];
      2'd2:    byte_sel = i_rdata[23:16];
      default: byte_sel = i_rdata[31:24];
    endcase
    half_sel = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_size)
      SIZE_BYTE: o_load_value = i_unsigned ? {24'h0, byte_sel}
                                           : {{24{byte_sel[7]}}, byte_sel};
      SIZE_HALF: o_load_value = i_unsigned ? {16'h0, half_sel}
                                           : {{16{half_sel[15]}}, half_sel};
      default:   o_load_value = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/memory_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : memory_access_unit
// Brief   : MEM stage: sized data-memory accesses over req/ready, MEM/WB reg.
// Revision: 1.0 - initial release
// ============================================================================
module memory_access_unit
  import mem_stage_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ValidIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        RegWriteIn,
  input  logic        MemToRegIn,
  input  logic        LoadStoreByteIn,
  input  logic        LoadStoreHalfIn,
  input  logic        LoadUnsignedIn,
  input  logic [31:0] AddressIn,
  input  logic [31:0] WriteDataIn,
  input  logic [4:0]  DestinationRegIn,
  output logic        MemReq,
  output logic        MemWe,
  output logic [29:0] MemAddr,
  output logic [3:0]  MemByteEn,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemReady,
  output logic        StallOut,
  output logic        ValidOut,
  output logic        RegWriteOut,
  output logic        MemToRegOut,
  output logic [4:0]  DestinationRegOut,
  output logic [31:0] ALUDataOut,
  output logic [31:0] ReadDataOut,
  output logic        MisalignOut
);

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [3:0]  byte_en_q, byte_en_d;
  logic [31:0] wdata_q, wdata_d;
  size_e       size_q, size_d;
  logic        load_unsigned_q, load_unsigned_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic [4:0]  dest_q, dest_d;

  logic        wb_valid_q, wb_valid_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;
  logic        misalign_q, misalign_d;

  size_e       size_in;
  logic        is_mem_op;
  logic        misaligned_in;
  logic        accept;
  logic [31:0] load_value;

  assign size_in       = decode_size(LoadStoreByteIn, LoadStoreHalfIn);
  assign is_mem_op     = MemReadIn | MemWriteIn;
  assign misaligned_in = is_misaligned(size_in, AddressIn[1:0]);
  assign accept        = ValidIn & is_mem_op & ~misaligned_in;

  mem_load_aligner u_load_aligner (
    .i_rdata      (MemRData),
    .i_lane       (req_addr_q[1:0]),
    .i_size       (size_q),
    .i_unsigned   (load_unsigned_q),
    .o_load_value (load_value)
  );

  always_comb begin
    state_d         = state_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    req_addr_d      = req_addr_q;
    byte_en_d       = byte_en_q;
    wdata_d         = wdata_q;
    size_d          = size_q;
    load_unsigned_d = load_unsigned_q;
    reg_write_d     = reg_write_q;
    mem_to_reg_d    = mem_to_reg_q;
    dest_d          = dest_q;

    // MEM/WB defaults to a bubble; each path below fills in what it loads.
    wb_valid_d      = 1'b0;
    wb_reg_write_d  = 1'b0;
    wb_mem_to_reg_d = 1'b0;
    wb_dest_d       = 5'd0;
    wb_alu_d        = 32'd0;
    wb_rdata_d      = 32'd0;
    misalign_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d         = ST_REQ;
          mem_req_d       = 1'b1;
          mem_we_d        = MemWriteIn;
          req_addr_d      = AddressIn;
          byte_en_d       = lane_enables(size_in, AddressIn[1:0]);
          wdata_d         = replicate_store(size_in, WriteDataIn);
          size_d          = size_in;
          load_unsigned_d = LoadUnsignedIn;
          reg_write_d     = RegWriteIn;
          mem_to_reg_d    = MemToRegIn;
          dest_d          = DestinationRegIn;
        end else if (ValidIn) begin
          // Misaligned ops retire without a register write.
          wb_valid_d      = 1'b1;
          wb_reg_write_d  = RegWriteIn & ~is_mem_op;
          wb_mem_to_reg_d = MemToRegIn;
          wb_dest_d       = DestinationRegIn;
          wb_alu_d        = AddressIn;
          misalign_d      = is_mem_op;
        end
      end
      ST_REQ: begin
        if (MemReady) begin
          state_d         = ST_IDLE;
          mem_req_d       = 1'b0;
          wb_valid_d      = 1'b1;
          wb_reg_write_d  = reg_write_q;
          wb_mem_to_reg_d = mem_to_reg_q;
          wb_dest_d       = dest_q;
          wb_alu_d        = req_addr_q;
          wb_rdata_d      = mem_we_q ? 32'd0 : load_value;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q         <= ST_IDLE;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      req_addr_q      <= 32'd0;
      byte_en_q       <= 4'd0;
      wdata_q         <= 32'd0;
      size_q          <= SIZE_BYTE;
      load_unsigned_q <= 1'b0;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      dest_q          <= 5'd0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_dest_q       <= 5'd0;
      wb_alu_q        <= 32'd0;
      wb_rdata_q      <= 32'd0;
      misalign_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      req_addr_q      <= req_addr_d;
      byte_en_q       <= byte_en_d;
      wdata_q         <= wdata_d;
      size_q          <= size_d;
      load_unsigned_q <= load_unsigned_d;
      reg_write_q     <= reg_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      dest_q          <= dest_d;
      wb_valid_q      <= wb_valid_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_dest_q       <= wb_dest_d;
      wb_alu_q        <= wb_alu_d;
      wb_rdata_q      <= wb_rdata_d;
      misalign_q      <= misalign_d;
    end
  end

  // Stall covers the accepting IDLE cycle and every REQ cycle still waiting.
  assign StallOut = (state_q == ST_IDLE) ? accept : ~MemReady;

  assign MemReq            = mem_req_q;
  assign MemWe             = mem_we_q;
  assign MemAddr           = req_addr_q[31:2];
  assign MemByteEn         = byte_en_q;
  assign MemWData          = wdata_q;
  assign ValidOut          = wb_valid_q;
  assign RegWriteOut       = wb_reg_write_q;
  assign MemToRegOut       = wb_mem_to_reg_q;
  assign DestinationRegOut = wb_dest_q;
  assign ALUDataOut        = wb_alu_q;
  assign ReadDataOut       = wb_rdata_q;
  assign MisalignOut       = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_memory_access_unit
// Brief   : Directed table plus randomized ops against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_memory_access_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ValidIn, MemReadIn, MemWriteIn, RegWriteIn, MemToRegIn;
  logic        LoadStoreByteIn, LoadStoreHalfIn, LoadUnsignedIn;
  logic [31:0] AddressIn, WriteDataIn, MemRData;
  logic [4:0]  DestinationRegIn;
  logic        MemReq, MemWe, MemReady, StallOut;
  logic [29:0] MemAddr;
  logic [3:0]  MemByteEn;
  logic [31:0] MemWData, ALUDataOut, ReadDataOut;
  logic        ValidOut, RegWriteOut, MemToRegOut, MisalignOut;
  logic [4:0]  DestinationRegOut;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid, rd, wr, rw, m2r, bsz, hsz, uns;
    logic [31:0] addr, wdata;
    logic [4:0]  dest;
    logic [31:0] rdata;
    int          waits;
  } op_t;

  typedef struct {
    logic        access, misalign, we;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic        vout, rwout;
    logic [31:0] rdout;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t exp;
  } vec_t;

  memory_access_unit dut (
    .Clk(Clk), .Reset(Reset), .ValidIn(ValidIn), .MemReadIn(MemReadIn),
    .MemWriteIn(MemWriteIn), .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn),
    .LoadStoreByteIn(LoadStoreByteIn), .LoadStoreHalfIn(LoadStoreHalfIn),
    .LoadUnsignedIn(LoadUnsignedIn), .AddressIn(AddressIn), .WriteDataIn(WriteDataIn),
    .DestinationRegIn(DestinationRegIn), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemByteEn(MemByteEn), .MemWData(MemWData),
    .MemRData(MemRData), .MemReady(MemReady), .StallOut(StallOut),
    .ValidOut(ValidOut), .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut),
    .DestinationRegOut(DestinationRegOut), .ALUDataOut(ALUDataOut),
    .ReadDataOut(ReadDataOut), .MisalignOut(MisalignOut)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk_op(input logic valid, rd, wr, rw, m2r, bsz, hsz, uns,
                                input logic [31:0] addr, wdata, input logic [4:0] dest,
                                input logic [31:0] rdata, input int waits);
    op_t o;
    o.valid = valid; o.rd = rd; o.wr = wr; o.rw = rw; o.m2r = m2r;
    o.bsz = bsz; o.hsz = hsz; o.uns = uns; o.addr = addr; o.wdata = wdata;
    o.dest = dest; o.rdata = rdata; o.waits = waits;
    return o;
  endfunction

  function automatic exp_t mk_exp(input logic access, misalign, we, input logic [3:0] be,
                                  input logic [31:0] mwdata, input logic vout, rwout,
                                  input logic [31:0] rdout);
    exp_t e;
    e.access = access; e.misalign = misalign; e.we = we; e.be = be;
    e.mwdata = mwdata; e.vout = vout; e.rwout = rwout; e.rdout = rdout;
    return e;
  endfunction

  // Reference: size in bytes, lane offset, and arithmetic extraction/extension.
  function automatic exp_t model(input op_t op);
    exp_t        e;
    int          nbytes, lane;
    logic [31:0] raw, mask;
    e = mk_exp(0, 0, 0, 4'h0, 32'h0, 0, 0, 32'h0);
    nbytes = op.bsz ? 1 : (op.hsz ? 2 : 4);
    lane   = int'(op.addr[1:0]);
    if (!op.valid) return e;
    e.vout = 1'b1;
    if (!(op.rd || op.wr)) begin
      e.rwout = op.rw;
      return e;
    end
    if ((lane % nbytes) != 0) begin
      e.misalign = 1'b1;
      return e;
    end
    e.access = 1'b1;
    e.we     = op.wr;
    e.rwout  = op.rw;
    e.be     = 4'(((1 << nbytes) - 1) << lane);
    if (nbytes == 1)      e.mwdata = {24'h0, op.wdata[7:0]} * 32'h01010101;
    else if (nbytes == 2) e.mwdata = {16'h0, op.wdata[15:0]} * 32'h00010001;
    else                  e.mwdata = op.wdata;
    if (!op.wr) begin
      raw = op.rdata >> (8 * lane);
      if (nbytes < 4) begin
        mask = 32'((64'd1 << (8 * nbytes)) - 64'd1);
        raw  = raw & mask;
        if (!op.uns && raw > (mask >> 1)) raw = raw - (mask + 32'd1);
      end
      e.rdout = raw;
    end
    return e;
  endfunction

  task automatic drive(input op_t op);
    ValidIn = op.valid; MemReadIn = op.rd; MemWriteIn = op.wr;
    RegWriteIn = op.rw; MemToRegIn = op.m2r; LoadStoreByteIn = op.bsz;
    LoadStoreHalfIn = op.hsz; LoadUnsignedIn = op.uns; AddressIn = op.addr;
    WriteDataIn = op.wdata; DestinationRegIn = op.dest;
  endtask

  // Upstream inputs are don't-care while the unit is stalled.
  task automatic drive_garbage();
    ValidIn = 1'($urandom); MemReadIn = 1'($urandom); MemWriteIn = 1'($urandom);
    RegWriteIn = 1'($urandom); MemToRegIn = 1'($urandom);
    LoadStoreByteIn = 1'($urandom); LoadStoreHalfIn = 1'($urandom);
    LoadUnsignedIn = 1'($urandom); AddressIn = $urandom; WriteDataIn = $urandom;
    DestinationRegIn = 5'($urandom);
  endtask

  task automatic check_wb(input op_t op, input exp_t e);
    chk("valid_out", ValidOut, e.vout);
    chk("regwrite_out", RegWriteOut, e.rwout);
    chk("read_data_out", ReadDataOut, e.rdout);
    if (e.vout) begin
      chk("alu_data_out", ALUDataOut, op.addr);
      chk("dest_out", DestinationRegOut, op.dest);
      if (!e.misalign) chk("mem_to_reg_out", MemToRegOut, op.m2r);
    end else begin
      chk("alu_data_bubble", ALUDataOut, 32'h0);
      chk("dest_bubble", DestinationRegOut, 5'd0);
      chk("mem_to_reg_bubble", MemToRegOut, 1'b0);
    end
  endtask

  task automatic run_op(input op_t op, input exp_t e);
    @(negedge Clk);
    drive(op);
    MemReady = 1'($urandom);
    MemRData = $urandom;
    #1 chk("stall_idle", StallOut, e.access);
    @(posedge Clk); #1;
    if (e.access) begin
      chk("req_issue", MemReq, 1'b1);
      chk("mem_we", MemWe, e.we);
      chk("mem_addr", MemAddr, op.addr[31:2]);
      chk("byte_en", MemByteEn, e.be);
      chk("mem_wdata", MemWData, e.mwdata);
      chk("valid_issue_bubble", ValidOut, 1'b0);
      chk("misalign_access", MisalignOut, 1'b0);
      for (int w = 0; w <= op.waits; w++) begin
        @(negedge Clk);
        drive_garbage();
        MemReady = (w == op.waits);
        MemRData = MemReady ? op.rdata : $urandom;
        #1 chk("stall_req", StallOut, !MemReady);
        @(posedge Clk); #1;
        if (w < op.waits) begin
          chk("req_held", MemReq, 1'b1);
          chk("we_held", MemWe, e.we);
          chk("addr_held", MemAddr, op.addr[31:2]);
          chk("be_held", MemByteEn, e.be);
          chk("wdata_held", MemWData, e.mwdata);
          chk("valid_wait_bubble", ValidOut, 1'b0);
        end else begin
          chk("req_drop", MemReq, 1'b0);
          check_wb(op, e);
        end
      end
    end else begin
      chk("req_none", MemReq, 1'b0);
      chk("misalign_out", MisalignOut, e.misalign);
      check_wb(op, e);
    end
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0].op  = mk_op(1,1,0,1,1,0,0,0, 32'h10, 32'h11223344, 5'd5, 32'hDEADBEEF, 0);
    vecs[0].exp = mk_exp(1,0,0, 4'hF, 32'h11223344, 1,1, 32'hDEADBEEF);
    vecs[1].op  = mk_op(1,1,0,1,1,1,0,0, 32'h13, 32'h0, 5'd6, 32'h80123456, 0);
    vecs[1].exp = mk_exp(1,0,0, 4'h8, 32'h0, 1,1, 32'hFFFFFF80);
    vecs[2].op  = mk_op(1,1,0,1,1,1,0,1, 32'h13, 32'h0, 5'd6, 32'h80123456, 1);
    vecs[2].exp = mk_exp(1,0,0, 4'h8, 32'h0, 1,1, 32'h00000080);
    vecs[3].op  = mk_op(1,0,1,0,0,0,1,0, 32'h22, 32'h0000BEEF, 5'd7, 32'h0, 0);
    vecs[3].exp = mk_exp(1,0,1, 4'hC, 32'hBEEFBEEF, 1,0, 32'h0);
    vecs[4].op  = mk_op(1,1,0,1,1,0,0,0, 32'h40, 32'h55, 5'd8, 32'h0BADF00D, 3);
    vecs[4].exp = mk_exp(1,0,0, 4'hF, 32'h55, 1,1, 32'h0BADF00D);
    vecs[5].op  = mk_op(1,1,0,1,1,0,0,0, 32'h6, 32'h0, 5'd9, 32'h0, 0);
    vecs[5].exp = mk_exp(0,1,0, 4'h0, 32'h0, 1,0, 32'h0);
    vecs[6].op  = mk_op(1,0,0,1,0,0,0,0, 32'h12345678, 32'h0, 5'd10, 32'h0, 0);
    vecs[6].exp = mk_exp(0,0,0, 4'h0, 32'h0, 1,1, 32'h0);
    vecs[7].op  = mk_op(0,1,0,1,1,0,0,0, 32'h20, 32'h0, 5'd11, 32'h0, 0);
    vecs[7].exp = mk_exp(0,0,0, 4'h0, 32'h0, 0,0, 32'h0);
    vecs[8].op  = mk_op(1,1,0,1,1,0,1,0, 32'h2, 32'h0, 5'd3, 32'h80017FFF, 0);
    vecs[8].exp = mk_exp(1,0,0, 4'hC, 32'h0, 1,1, 32'hFFFF8001);
    vecs[9].op  = mk_op(1,1,0,1,0,1,1,1, 32'h1, 32'h12, 5'd12, 32'h0000AB00, 2);
    vecs[9].exp = mk_exp(1,0,0, 4'h2, 32'h12121212, 1,1, 32'h000000AB);
    vecs[10].op  = mk_op(1,0,1,1,0,0,1,0, 32'h5, 32'hFFFF, 5'd13, 32'h0, 0);
    vecs[10].exp = mk_exp(0,1,0, 4'h0, 32'h0, 1,0, 32'h0);
    vecs[11].op  = mk_op(1,1,1,1,0,0,0,0, 32'h8, 32'hCAFEF00D, 5'd14, 32'h12345678, 1);
    vecs[11].exp = mk_exp(1,0,1, 4'hF, 32'hCAFEF00D, 1,1, 32'h0);
    vecs[12].op  = mk_op(1,1,0,0,1,0,1,1, 32'h100, 32'h0, 5'd15, 32'h1234ABCD, 0);
    vecs[12].exp = mk_exp(1,0,0, 4'h3, 32'h0, 1,0, 32'h0000ABCD);

    // Reset state
    Reset = 1'b1; MemReady = 1'b0; MemRData = 32'h0;
    drive(mk_op(0,0,0,0,0,0,0,0, 32'h0, 32'h0, 5'd0, 32'h0, 0));
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_req", MemReq, 1'b0);       chk("rst_we", MemWe, 1'b0);
    chk("rst_addr", MemAddr, 30'h0);    chk("rst_be", MemByteEn, 4'h0);
    chk("rst_wdata", MemWData, 32'h0);  chk("rst_stall", StallOut, 1'b0);
    chk("rst_misalign", MisalignOut, 1'b0);
    chk("rst_valid", ValidOut, 1'b0);   chk("rst_rw", RegWriteOut, 1'b0);
    chk("rst_m2r", MemToRegOut, 1'b0);  chk("rst_dest", DestinationRegOut, 5'd0);
    chk("rst_alu", ALUDataOut, 32'h0);  chk("rst_rdata", ReadDataOut, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 13; i++) run_op(vecs[i].op, vecs[i].exp);

    // Reset while waiting in REQ aborts the access
    @(negedge Clk);
    drive(mk_op(1,1,0,1,1,0,0,0, 32'h80, 32'h0, 5'd4, 32'h0, 0));
    MemReady = 1'b0;
    @(posedge Clk); #1;
    chk("abort_req_up", MemReq, 1'b1);
    @(negedge Clk);
    drive_garbage();
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    drive(mk_op(0,0,0,0,0,0,0,0, 32'h0, 32'h0, 5'd0, 32'h0, 0));
    @(posedge Clk); #1;
    chk("abort_req", MemReq, 1'b0);
    chk("abort_stall", StallOut, 1'b0);
    chk("abort_valid", ValidOut, 1'b0);
    chk("abort_rw", RegWriteOut, 1'b0);
    chk("abort_alu", ALUDataOut, 32'h0);
    chk("abort_rdata", ReadDataOut, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    MemReady = 1'b1;
    MemRData = 32'hFFFFFFFF;
    #1 chk("late_ready_stall", StallOut, 1'b0);
    @(posedge Clk); #1;
    chk("late_ready_valid", ValidOut, 1'b0);
    chk("late_ready_req", MemReq, 1'b0);
    chk("late_ready_rdata", ReadDataOut, 32'h0);

    // Randomized ops against the reference model
    for (int i = 0; i < 200; i++) begin
      op_t o;
      int  kind;
      kind = $urandom_range(0, 3);
      o = mk_op($urandom_range(0, 7) != 0, kind[0], kind[1], 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                5'($urandom), $urandom, $urandom_range(0, 3));
      run_op(o, model(o));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_access_unit.md
# memory_access_unit

Memory-stage block of the pipelined MIPS datapath. It receives the EX/MEM outputs of the execute stage (ALU result, store data, load/store size and control bits) and performs byte, halfword or word accesses against the data memory through a request/ready handshake. While an access is outstanding it stalls the upstream pipeline. It registers the MEM/WB fields for writeback.

## Interface
- No parameters. Data width is fixed at 32 bits and the register index at 5 bits.
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- ValidIn  in  1  EX/MEM slot holds a real instruction
- MemReadIn, MemWriteIn  in  1 each  load / store request
- RegWriteIn, MemToRegIn  in  1 each  writeback control, passed through
- LoadStoreByteIn, LoadStoreHalfIn  in  1 each  access size (neither set means word; both set means byte)
- LoadUnsignedIn  in  1  zero-extend byte/half loads (lbu/lhu)
- AddressIn  in  32  byte address (execute-stage ALU result)
- WriteDataIn  in  32  store data, right-justified
- DestinationRegIn  in  5  writeback register
- MemReq  out  1  access request to data memory
- MemWe  out  1  write enable
- MemAddr  out  30  word address (AddressIn[31:2])
- MemByteEn  out  4  byte-lane enables, lane n = bits [8n+7:8n]
- MemWData  out  32  store data replicated into the addressed lanes
- MemRData  in  32  read data, valid when MemReady=1
- MemReady  in  1  memory completes the access this cycle
- StallOut  out  1  hold IF/ID/EX and EX/MEM this cycle
- ValidOut, RegWriteOut, MemToRegOut  out  1 each  MEM/WB register
- DestinationRegOut  out  5  MEM/WB register
- ALUDataOut, ReadDataOut  out  32 each  MEM/WB register
- MisalignOut  out  1  one-cycle pulse: misaligned access was dropped

## Operation
- Endianness is little-endian. Byte lane = AddressIn[1:0]. Halfword lane = AddressIn[1].
- Alignment rules:
  - Halfword is misaligned when AddressIn[0]=1.
  - Word is misaligned when AddressIn[1:0]≠0.
  - Byte is always aligned.
- A misaligned access issues no memory request and does not stall.
  - MEM/WB is loaded with RegWriteOut=0 and ValidOut=1.
  - MisalignOut=1 for that cycle.
- A non-memory instruction (ValidIn=1, MemRead=MemWrite=0) passes to MEM/WB at the next edge with StallOut=0.
  - ReadDataOut=0 and ALUDataOut=AddressIn.
- If MemReadIn and MemWriteIn are both 1, the store takes precedence.
- The FSM has two states, IDLE and REQ.
  - IDLE: an aligned memory op with ValidIn=1 sets StallOut=1 and latches the address, lane enables, replicated store data, size, sign and control. The next state is REQ. MEM/WB is loaded with a bubble (ValidOut=0).
  - REQ: MemReq=1 and the latched MemWe/MemAddr/MemByteEn/MemWData are held stable.
    - MemReady=0: StallOut=1 and the FSM stays in REQ.
    - MemReady=1: StallOut=0, the FSM returns to IDLE and MEM/WB is loaded at that edge.
- Load extraction:
  - The selected byte or half is sign- or zero-extended per LoadUnsignedIn. A word is taken as-is.
  - A store writes ReadDataOut=0 and RegWriteOut=RegWriteIn.
- Lane enables:
  - byte: 4'b0001<<lane
  - half: 4'b0011 or 4'b1100
  - word: 4'b1111
- ValidIn=0 in IDLE loads a bubble into MEM/WB: all MEM/WB outputs 0.

## Timing
- Reset values: MemReq=0, MemWe=0, MemAddr=0, MemByteEn=0, MemWData=0, StallOut=0, MisalignOut=0, all MEM/WB outputs 0, state IDLE.
- Reset during REQ aborts the access. MemReq drops at the next edge and no MEM/WB load occurs.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op: 2 + N cycles, where N is the number of REQ cycles with MemReady=0.
  - MemReady sampled high in the first REQ cycle gives a 2-cycle op.
- StallOut is combinational from state, the IDLE-cycle inputs and MemReady. Memory outputs are registered.
- MemReady=1 while in IDLE is ignored.
- A new memory op can be accepted in the cycle after REQ completes; there is no back-to-back overlap.

## Structure
- A shared package, mem_stage_pkg, holds:
  - the state enum (IDLE, REQ)
  - size encodings (BYTE, HALF, WORD)
  - lane-enable constants
- One combinational sub-module, mem_load_aligner, takes (MemRData, lane, size, unsigned) and produces the extended load value.
- The FSM, the request registers and the MEM/WB register live in the top.

## Test plan
- Word load:
  - Stimulus: AddressIn=0x10, MemRData=0xDEADBEEF, MemReady high in first REQ.
  - Response: MemByteEn=4'b1111, MemAddr=0x4, StallOut high exactly 1 cycle, ReadDataOut=0xDEADBEEF two cycles after issue.
- Byte load, signed and unsigned:
  - Stimulus: AddressIn=0x13, MemRData=0x80123456.
  - Response: signed gives ReadDataOut=0xFFFFFF80; LoadUnsignedIn=1 gives 0x00000080.
- Halfword store:
  - Stimulus: AddressIn=0x22, WriteDataIn=0x0000BEEF.
  - Response: MemWe=1, MemByteEn=4'b1100, MemWData=0xBEEFBEEF.
- Wait states:
  - Stimulus: MemReady held low 3 cycles.
  - Response: StallOut high 4 cycles, MemAddr/MemWData stable throughout, single MEM/WB load.
- Misaligned word:
  - Stimulus: AddressIn=0x6.
  - Response: MemReq never asserted, MisalignOut=1 one cycle, RegWriteOut=0.
- Reset in REQ:
  - Stimulus: Reset asserted mid-wait.
  - Response: next cycle MemReq=0, StallOut=0, MEM/WB all zero; a later MemReady pulse has no effect.
